// File: rtl/result_writeback_if.sv
// result_writeback_if: result stream (valid/ready) plus Avalon-style SDRAM
// write bus. master = the write-back block, slave = producer/memory side.
interface result_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26
);
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic              result_ready;
    logic              sdram_write;
    logic [ADDR_W-1:0] sdram_address;
    logic [DATA_W-1:0] sdram_writedata;
    logic              sdram_waitrequest;

    modport master (
        input  result_valid,
        input  result,
        input  sdram_waitrequest,
        output result_ready,
        output sdram_write,
        output sdram_address,
        output sdram_writedata
    );

    modport slave (
        output result_valid,
        output result,
        output sdram_waitrequest,
        input  result_ready,
        input  sdram_write,
        input  sdram_address,
        input  sdram_writedata
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: buffers filtered pixel words in a FIFO and writes them to
// SDRAM at consecutive word addresses from a programmed base.
// Ports: clk, n_rst (sync, active-low), start/base_address/image_width/
// image_height (frame setup, sampled on start in IDLE), bus (result stream
// in, SDRAM write master out), busy (RUN), finish_flag (one-cycle done pulse).
module result_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26,
    parameter int DIM_W  = 13,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_address,
    input  logic [DIM_W-1:0]        image_width,
    input  logic [DIM_W-1:0]        image_height,
    result_writeback_if.master      bus,
    output logic                    busy,
    output logic                    finish_flag
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = 2 * DIM_W;
    localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic [CW-1:0]     r_total;
    logic [CW-1:0]     r_accepted;
    logic [CW-1:0]     r_written;
    logic [ADDR_W-1:0] r_addr;

    logic          w_run;
    logic          w_ready;
    logic          w_write;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_total_in;

    assign w_run      = (r_state == S_RUN);
    // Ready ignores a same-cycle pop so it never depends on waitrequest.
    assign w_ready    = w_run && (r_count < C_DEPTH) && (r_accepted < r_total);
    assign w_write    = w_run && (r_count != '0);
    assign w_push     = bus.result_valid && w_ready;
    assign w_pop      = w_write && !bus.sdram_waitrequest;
    assign w_total_in = CW'(image_width) * CW'(image_height);

    assign bus.result_ready    = w_ready;
    assign bus.sdram_write     = w_write;
    assign bus.sdram_address   = r_addr;
    assign bus.sdram_writedata = r_mem[r_rd_ptr];
    assign busy                = w_run;
    assign finish_flag         = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_total    <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_addr     <= '0;
            // Storage is cleared so the write-data output reads 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= base_address;
                        r_total    <= w_total_in;
                        r_accepted <= '0;
                        r_written  <= '0;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_count    <= '0;
                        r_state    <= (w_total_in != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= bus.result;
                        r_wr_ptr        <= r_wr_ptr + 1'b1;
                        r_accepted      <= r_accepted + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_addr    <= r_addr + ADDR_W'(4);
                        r_written <= r_written + 1'b1;
                        if (r_written + CW'(1) == r_total) begin
                            r_state <= S_DONE;
                        end
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: randomized frames against a queue-based address/data
// model; a negedge monitor scores every SDRAM transfer and the finish pulse.
module tb_result_writeback;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 26;
    localparam int DIM_W  = 13;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_address = '0;
    logic [DIM_W-1:0]  image_width = '0;
    logic [DIM_W-1:0]  image_height = '0;
    logic              busy;
    logic              finish_flag;

    result_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    result_writeback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .base_address (base_address),
        .image_width  (image_width),
        .image_height (image_height),
        .bus          (bus),
        .busy         (busy),
        .finish_flag  (finish_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                last;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    logic [ADDR_W-1:0] m_base;
    int   m_total = 0;
    int   m_acc = 0;
    bit   m_busy = 0;
    bit   abort = 0;
    bit   fin_arm = 0;
    bit   fin_seen = 0;
    int   xfer_cnt = 0;
    int   first_acc_cyc = -1;
    int   first_wr_cyc = -1;
    int   wait_mode = 0;
    int   gap_pct = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] b, input int w,
                               input int h);
        start        = 1'b1;
        base_address = b;
        image_width  = DIM_W'(w);
        image_height = DIM_W'(h);
        if (!m_busy) begin
            m_base        = b;
            m_total       = w * h;
            m_acc         = 0;
            xfer_cnt      = 0;
            first_acc_cyc = -1;
            first_wr_cyc  = -1;
            m_busy        = (m_total != 0);
            if (m_total == 0) fin_arm = 1;
        end
        tick();
        start = 1'b0;
    endtask

    // Offers words until n are accepted, the cycle budget runs out or abort.
    task automatic feed(input int n, input int maxcyc,
                        input logic [DATA_W-1:0] seed, input bit seq,
                        output int got);
        int   c;
        exp_t e;
        got = 0;
        c   = 0;
        while (got < n && c < maxcyc && !abort) begin
            bus.result_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.result = seq ? seed + DATA_W'(got) : DATA_W'($urandom);
            chk("ready_legal",
                bus.result_ready && (!m_busy || m_acc >= m_total), 1'b0);
            if (bus.result_valid && bus.result_ready && m_busy
                && m_acc < m_total) begin
                e.addr = m_base + ADDR_W'(m_acc * 4);
                e.data = bus.result;
                e.last = (m_acc == m_total - 1);
                exp_q.push_back(e);
                if (m_acc == 0) first_acc_cyc = cyc;
                m_acc++;
                got++;
            end
            tick();
            c++;
        end
        bus.result_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!fin_seen && i < budget) begin
            tick();
            i++;
        end
        chk("finish_seen", fin_seen, 1'b1);
        chk("xfer_count", xfer_cnt, m_total);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_after", busy, 1'b0);
        fin_seen = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.result_ready, 1'b0);
        chk({tag, "_write"}, bus.sdram_write, 1'b0);
        chk({tag, "_addr"}, bus.sdram_address, '0);
        chk({tag, "_data"}, bus.sdram_writedata, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_finish"}, finish_flag, 1'b0);
    endtask

    // Monitor: scores transfers, stall stability and the finish pulse.
    initial begin
        bit                fin_due;
        bit                nxt;
        bit                prev_stall;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        exp_t              e;
        fin_due    = 0;
        prev_stall = 0;
        pa         = '0;
        pd         = '0;
        forever begin
            @(negedge clk);
            nxt = 0;
            if (n_rst) begin
                chk("finish_flag", finish_flag, fin_due);
                if (finish_flag) fin_seen = 1;
                if (prev_stall) begin
                    chk("stall_write", bus.sdram_write, 1'b1);
                    chk("stall_addr", bus.sdram_address, pa);
                    chk("stall_data", bus.sdram_writedata, pd);
                end
                if (bus.sdram_write && first_wr_cyc < 0) first_wr_cyc = cyc;
                if (bus.sdram_write && !bus.sdram_waitrequest) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", bus.sdram_address, e.addr);
                        chk("wr_data", bus.sdram_writedata, e.data);
                        if (e.last) begin
                            nxt    = 1;
                            m_busy = 0;
                        end
                    end
                end
                if (fin_arm) nxt = 1;
            end
            fin_arm    = 0;
            fin_due    = nxt;
            prev_stall = n_rst && bus.sdram_write && bus.sdram_waitrequest;
            pa         = bus.sdram_address;
            pd         = bus.sdram_writedata;
        end
    end

    initial begin
        forever begin
            tick();
            if (wait_mode == 1) begin
                bus.sdram_waitrequest = ($urandom_range(0, 2) == 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int got;
        int k;
        int w;
        int h;
        bus.result_valid      = 1'b0;
        bus.result            = '0;
        bus.sdram_waitrequest = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        n_rst = 1'b1;
        tick();

        // Basic 2x2 frame.
        start_frame(26'h100, 2, 2);
        feed(4, 50, 32'hA0, 1'b1, got);
        chk("basic_accepts", got, 4);
        wait_done(50);
        chk("basic_latency", first_wr_cyc, first_acc_cyc + 1);

        // Backpressure: 12-cycle stall from the first request.
        wait_mode = 2;
        bus.sdram_waitrequest = 1'b1;
        start_frame(26'h100, 16, 1);
        fork
            begin
                feed(16, 200, 32'hB00, 1'b1, got);
            end
            begin
                k = 0;
                while (!bus.sdram_write && k < 50) begin
                    tick();
                    k++;
                end
                chk("bp_req_seen", bus.sdram_write, 1'b1);
                repeat (11) tick();
                @(negedge clk);
                chk("bp_full_acc", m_acc, 8);
                chk("bp_ready_full", bus.result_ready, 1'b0);
                chk("bp_addr", bus.sdram_address, 26'h100);
                chk("bp_data", bus.sdram_writedata, 32'hB00);
                tick();
                bus.sdram_waitrequest = 1'b0;
            end
        join
        chk("bp_accepts", got, 16);
        wait_done(100);
        wait_mode = 0;

        // Degenerate size.
        start_frame(26'h180, 0, 5);
        feed(1, 10, 32'h0, 1'b0, got);
        chk("deg_accepts", got, 0);
        wait_done(10);

        // Over-supply: 5 words offered, 3 taken.
        start_frame(26'h400, 3, 1);
        feed(5, 30, 32'hC0, 1'b1, got);
        chk("over_accepts", got, 3);
        wait_done(20);

        // Start while busy is ignored.
        gap_pct = 30;
        start_frame(26'h300, 4, 2);
        fork
            feed(8, 200, 32'h0, 1'b0, got);
            begin
                tick();
                tick();
                start_frame(26'h900, 6, 6);
            end
        join
        chk("busy_start_accepts", got, 8);
        wait_done(100);

        // Address wrap at the top of the space.
        gap_pct = 0;
        start_frame(26'h3FFFFF8, 4, 1);
        feed(4, 50, 32'h0, 1'b0, got);
        chk("wrap_accepts", got, 4);
        wait_done(50);

        // Random frames with random stalls and input gaps.
        wait_mode = 1;
        gap_pct   = 25;
        for (int f = 0; f < 4; f++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            start_frame(ADDR_W'($urandom) & ~ADDR_W'(3), w, h);
            feed(w * h, 500, 32'h0, 1'b0, got);
            chk("rand_accepts", got, w * h);
            wait_done(200);
        end
        wait_mode = 0;
        bus.sdram_waitrequest = 1'b0;
        gap_pct = 0;

        // Reset mid-frame after 10 transfers.
        start_frame(26'h40, 8, 8);
        fork
            feed(64, 400, 32'h0, 1'b0, got);
            begin
                k = 0;
                while (xfer_cnt < 10 && k < 100) begin
                    tick();
                    k++;
                end
                chk("rst_xfers", xfer_cnt >= 10, 1'b1);
                n_rst  = 1'b0;
                abort  = 1;
                exp_q.delete();
                m_busy = 0;
                tick();
                n_rst = 1'b1;
                @(negedge clk);
                chk_reset_outputs("midrst");
            end
        join
        abort = 0;
        repeat (5) tick();
        chk("midrst_no_finish", fin_seen, 1'b0);
        start_frame(26'h200, 2, 3);
        feed(6, 50, 32'hD0, 1'b1, got);
        chk("after_rst_accepts", got, 6);
        wait_done(50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Write-side counterpart to the SDRAM pixel-read path of the custom logic.
- Accepts 32-bit filtered pixel words from the filter top level.
- Buffers them in a small FIFO and issues Avalon-style single-word write requests to SDRAM at consecutive addresses from a programmed base.
- Asserts a one-cycle finish pulse once width*height words have been written.

Parameters:
- DATA_W, 32, width of a result word and of SDRAM write data
- ADDR_W, 26, SDRAM byte address width
- DIM_W, 13, width of the image_width / image_height fields
- DEPTH, 8, FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame write-back (IDLE only)
- base_address  in  ADDR_W  first SDRAM byte address; sampled on start
- image_width  in  DIM_W  pixels per row; sampled on start
- image_height  in  DIM_W  rows; sampled on start
- result_valid  in  1  result word offered
- result  in  DATA_W  filtered pixel word
- result_ready  out  1  block accepts result this cycle
- sdram_write  out  1  write request
- sdram_address  out  ADDR_W  write byte address
- sdram_writedata  out  DATA_W  write data
- sdram_waitrequest  in  1  slave stall; a transfer completes when sdram_write=1 and sdram_waitrequest=0
- busy  out  1  high in RUN
- finish_flag  out  1  one-cycle pulse at frame completion

Behaviour:
Clock and reset:
- Single clock, clk. n_rst is synchronous and active-low, sampled on the rising edge of clk.
- Under reset:
  - state=IDLE; FIFO pointers and count = 0
  - accepted and written counters = 0; address register = 0
  - outputs: result_ready=0, sdram_write=0, sdram_address=0, sdram_writedata=0, busy=0, finish_flag=0
- Reset mid-frame abandons the frame: pending FIFO contents are discarded, no further writes occur, and no finish pulse is produced.

States:
- IDLE: result_ready=0, sdram_write=0.
  - On start: latch base into the address register and total = image_width*image_height (2*DIM_W bits, unsigned); clear counters and FIFO.
  - Go to RUN if total!=0, else go to DONE.
- RUN: busy=1.
  - Go to DONE in the cycle after the transfer that makes written==total.
- DONE: finish_flag=1 for exactly this cycle; return to IDLE next cycle.
- start is ignored in RUN and DONE.

Accept side:
- result_ready = (state==RUN) && (fifo_count<DEPTH) && (accepted<total).
- A push occurs on result_valid && result_ready; accepted increments on each push.
- Ready does not consider a same-cycle pop: when full, ready=0 even if a pop occurs that cycle.
- Words offered beyond total are never accepted (ready stays 0).

Write side:
- sdram_write = (state==RUN) && (fifo_count!=0).
- sdram_writedata = FIFO head, registered storage.
- sdram_address = address register.
- On a completed transfer: pop the FIFO, address += 4, written += 1.
- While sdram_waitrequest=1, address and data hold stable.
- Simultaneous push and pop: count unchanged, both pointers advance.

Arithmetic and ordering:
- Pointers wrap modulo DEPTH.
- Address wraps modulo 2^ADDR_W without error.
- Latency: a word accepted in cycle N can appear on sdram_write at cycle N+1 at the earliest.
- With waitrequest=0 and continuous input, throughput is one word per cycle.
- Write order equals accept order; no data is dropped or duplicated.

Test Plan:
- Basic frame:
  - Stimulus: width=2, height=2, base=0x0000100, results 0xA0..0xA3 back-to-back, waitrequest=0.
  - Response: four writes to 0x100, 0x104, 0x108, 0x10C with data A0..A3; first write 1 cycle after the first accept; finish_flag high one cycle, 1 cycle after the last transfer; busy low afterward.
- Backpressure:
  - Stimulus: width=16, height=1, waitrequest held 1 for 12 cycles after the first request.
  - Response: FIFO reaches 8, result_ready=0 while full; address/data stable at 0x100/first word throughout the stall; all 16 words later written in order with no loss.
- Degenerate size:
  - Stimulus: width=0, height=5, start.
  - Response: no sdram_write ever; finish_flag one cycle after the start cycle; result_ready never 1.
- Over-supply:
  - Stimulus: width=3, height=1, result_valid held high with 5 distinct words.
  - Response: only the first 3 accepted (ready low after the 3rd); exactly 3 writes.
- Reset mid-frame:
  - Stimulus: width=8, height=8, n_rst low for 1 cycle after 10 transfers.
  - Response: the next cycle shows all outputs at reset values; no finish_flag.
  - Then a new start with base=0x200 writes from 0x200 correctly.
- Start while busy:
  - Stimulus: second start pulse with a different base mid-frame.
  - Response: ignored; address sequence and total unchanged.
